// File: rtl/fp_compare_pipe.sv
// fp_compare_pipe: two-stage pipelined IEEE-754 predicate comparator; define FP_CMP_MINMAX_EN to add out_min/out_max
module fp_compare_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_a,
  input  logic [EXP_W+MAN_W:0]   in_b,
  input  logic [2:0]             in_op,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_result,
  output logic                   out_invalid,
  output logic [TAG_W-1:0]       out_tag
`ifdef FP_CMP_MINMAX_EN
  ,
  output logic [EXP_W+MAN_W:0]   out_min,
  output logic [EXP_W+MAN_W:0]   out_max
`endif
);
  localparam int W = 1 + EXP_W + MAN_W;
  typedef struct packed {
    logic             a_nan;
    logic             a_snan;
    logic             a_zero;
    logic             b_nan;
    logic             b_snan;
    logic             b_zero;
    logic             mag_gt;
    logic             mag_eq;
    logic             sign_a;
    logic             sign_b;
    logic [2:0]       op;
    logic [TAG_W-1:0] tag;
  } s1_t;
  s1_t s1_in, s1_d, s1_q;
  logic s1_valid_d, s1_valid_q;
  logic out_valid_d, out_valid_q;
  logic out_result_d, out_result_q;
  logic out_invalid_d, out_invalid_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;
  logic s1_adv, s2_adv, s2_load;
  logic both_zero, unord, eq, lt, gt, ordered, signaling, res_c, inv_c;
  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign s2_load  = s2_adv && s1_valid_q;
  // classify operands and compare raw magnitudes ahead of the first register
  always_comb begin
    s1_in.a_nan  = &in_a[W-2:MAN_W] && |in_a[MAN_W-1:0];
    s1_in.a_snan = &in_a[W-2:MAN_W] && |in_a[MAN_W-1:0] && !in_a[MAN_W-1];
    s1_in.a_zero = ~|in_a[W-2:0];
    s1_in.b_nan  = &in_b[W-2:MAN_W] && |in_b[MAN_W-1:0];
    s1_in.b_snan = &in_b[W-2:MAN_W] && |in_b[MAN_W-1:0] && !in_b[MAN_W-1];
    s1_in.b_zero = ~|in_b[W-2:0];
    s1_in.mag_gt = in_a[W-2:0] > in_b[W-2:0];
    s1_in.mag_eq = in_a[W-2:0] == in_b[W-2:0];
    s1_in.sign_a = in_a[W-1];
    s1_in.sign_b = in_b[W-1];
    s1_in.op     = in_op;
    s1_in.tag    = in_tag;
    s1_valid_d   = s1_adv ? in_valid : s1_valid_q;
    s1_d         = (in_valid && s1_adv) ? s1_in : s1_q;
  end
  // resolve the ordering relation and the selected predicate from stage-1 state
  always_comb begin
    both_zero     = s1_q.a_zero && s1_q.b_zero;
    unord         = s1_q.a_nan || s1_q.b_nan;
    eq            = both_zero || (s1_q.sign_a == s1_q.sign_b && s1_q.mag_eq);
    lt            = !eq && ((s1_q.sign_a != s1_q.sign_b) ? s1_q.sign_a :
                            (s1_q.sign_a ? s1_q.mag_gt : !s1_q.mag_gt));
    gt            = !eq && !lt;
    ordered       = s1_q.op == 3'd0 ? eq  :
                    s1_q.op == 3'd1 ? !eq :
                    s1_q.op == 3'd2 ? lt  :
                    s1_q.op == 3'd3 ? !gt :
                    s1_q.op == 3'd4 ? gt  :
                    s1_q.op == 3'd5 ? !lt :
                    s1_q.op == 3'd7;
    signaling     = s1_q.op >= 3'd2 && s1_q.op <= 3'd5;
    res_c         = unord ? (s1_q.op == 3'd1 || s1_q.op == 3'd6) : ordered;
    inv_c         = s1_q.a_snan || s1_q.b_snan || (unord && signaling);
    out_valid_d   = s2_adv ? s1_valid_q : out_valid_q;
    out_result_d  = s2_load ? res_c : out_result_q;
    out_invalid_d = s2_load ? inv_c : out_invalid_q;
    out_tag_d     = s2_load ? s1_q.tag : out_tag_q;
  end
  // both pipeline stages; reset empties the pipe and clears the visible outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q    <= 1'b0;
      s1_q          <= '0;
      out_valid_q   <= 1'b0;
      out_result_q  <= 1'b0;
      out_invalid_q <= 1'b0;
      out_tag_q     <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s1_q          <= s1_d;
      out_valid_q   <= out_valid_d;
      out_result_q  <= out_result_d;
      out_invalid_q <= out_invalid_d;
      out_tag_q     <= out_tag_d;
    end
  end
  assign out_valid   = out_valid_q;
  assign out_result  = out_result_q;
  assign out_invalid = out_invalid_q;
  assign out_tag     = out_tag_q;
`ifdef FP_CMP_MINMAX_EN
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  logic [W-1:0] a_d, a_q, b_d, b_q, min_c, max_c;
  logic [W-1:0] out_min_d, out_min_q, out_max_d, out_max_q;
  // raw operands ride along stage 1 so stage 2 can pick min/max
  always_comb begin
    a_d = (in_valid && s1_adv) ? in_a : a_q;
    b_d = (in_valid && s1_adv) ? in_b : b_q;
  end
  // NaN operands lose to numbers; both-NaN yields the canonical quiet NaN; -0 < +0
  always_comb begin
    min_c     = (s1_q.a_nan && s1_q.b_nan) ? QNAN : s1_q.a_nan ? b_q : s1_q.b_nan ? a_q :
                both_zero ? {1'b1, {(W-1){1'b0}}} : lt ? a_q : b_q;
    max_c     = (s1_q.a_nan && s1_q.b_nan) ? QNAN : s1_q.a_nan ? b_q : s1_q.b_nan ? a_q :
                both_zero ? '0 : gt ? a_q : b_q;
    out_min_d = s2_load ? min_c : out_min_q;
    out_max_d = s2_load ? max_c : out_max_q;
  end
  // min/max registers share the stage-2 hold behaviour of out_result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      out_min_q <= '0;
      out_max_q <= '0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      out_min_q <= out_min_d;
      out_max_q <= out_max_d;
    end
  end
  assign out_min = out_min_q;
  assign out_max = out_max_q;
`endif
endmodule
